// File: rtl/sim_status_mbox_pkg.sv
// Shared constants for the simulation status mailbox: register offsets,
// event codes, FSM encoding and STATUS bit positions.
package sim_mbox_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_CYCLES = 5'h04;
    localparam logic [4:0] OFF_COUNTS = 5'h08;
    localparam logic [4:0] OFF_INFO   = 5'h10;
    localparam logic [4:0] OFF_WARN   = 5'h14;
    localparam logic [4:0] OFF_PASS   = 5'h18;
    localparam logic [4:0] OFF_FAIL   = 5'h1C;

    localparam logic [1:0] EVT_INFO = 2'd0;
    localparam logic [1:0] EVT_WARN = 2'd1;
    localparam logic [1:0] EVT_PASS = 2'd2;
    localparam logic [1:0] EVT_FAIL = 2'd3;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_END   = 2'd2;

    localparam int STAT_DONE    = 2;
    localparam int STAT_PASSED  = 3;
    localparam int STAT_FAILED  = 4;
    localparam int STAT_TIMEOUT = 5;
    localparam int STAT_OVF     = 6;

    typedef struct packed {
        logic [1:0]  code;
        logic [31:0] data;
    } evt_t;

endpackage

// File: rtl/sim_status_mbox_if.sv
// RAM-side access bus plus the event pop stream of the status mailbox.
interface sim_status_mbox_if #(
    parameter int BWIDTH = 64
) ();

    logic              cs;
    logic              we;
    logic [31:0]       addr;
    logic [BWIDTH-1:0] mask;
    logic [BWIDTH-1:0] wrData;
    logic [BWIDTH-1:0] rdData;
    logic              evtVld;
    logic [1:0]        evtCode;
    logic [31:0]       evtData;
    logic              evtRdy;

    modport master (
        output cs, we, addr, mask, wrData, evtRdy,
        input  rdData, evtVld, evtCode, evtData
    );

    modport slave (
        input  cs, we, addr, mask, wrData, evtRdy,
        output rdData, evtVld, evtCode, evtData
    );

endinterface

// File: rtl/sim_status_mbox_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot on the same edge.
module sim_mbox_fifo
    import sim_mbox_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  evt_t pushData_i,
    input  logic pop_i,
    output evt_t head_o,
    output logic headVld_o,
    output logic full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    evt_t          mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic          empty;
    logic          doPush;
    logic          doPop;

    assign empty     = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign doPop     = pop_i && !empty;
    assign doPush    = push_i && (!full_o || doPop);
    assign headVld_o = !empty;
    assign head_o    = empty ? '0 : mem_q[rdPtr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q   <= '{default: '0};
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= pushData_i;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sim_status_mbox.sv
// Memory-mapped simulation status mailbox: decodes INFO/WARN/PASS/FAIL writes,
// runs the watchdog and drain FSM, and queues events for the bench to display.
module sim_status_mbox
    import sim_mbox_pkg::*;
#(
    parameter int          BWIDTH       = 64,
    parameter logic [31:0] ADDR_BASE    = 32'hFFFFFFE0,
    parameter int unsigned MAX_CLOCKS   = 100000,
    parameter int unsigned FINISH_DELAY = 4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sim_status_mbox_if.slave  bus,
    output logic              done_o,
    output logic              passed_o,
    output logic              failed_o,
    output logic              timeout_o,
    output logic [15:0]       warnCnt_o
);

    localparam int DW = (FINISH_DELAY > 1) ? $clog2(FINISH_DELAY) : 1;

    logic [1:0]    state_q, state_d;
    logic [31:0]   cycleCnt_q, cycleCnt_d;
    logic [DW-1:0] drainCnt_q, drainCnt_d;
    logic          passed_q, passed_d;
    logic          failed_q, failed_d;
    logic          timeout_q, timeout_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   infoCnt_q, infoCnt_d;
    logic [15:0]   warnCnt_q, warnCnt_d;
    logic [31:0]   rdData_q, rdData_d;

    logic [31:0] laneMask;
    logic [31:0] laneWr;
    logic [4:0]  offset;
    logic [1:0]  evtCode;
    logic        hit, wrEn, kick, isEvt, resultWr, wdExpire, done;
    logic [31:0] rdWord;
    evt_t        pushEvt, headEvt;
    logic        fifoVld, fifoFull;

    // On a 64-bit bus ADDR[2] picks the 32-bit lane; a 32-bit bus has only one.
    assign laneMask = (BWIDTH == 64 && bus.addr[2]) ? bus.mask[BWIDTH-1 -: 32]   : bus.mask[31:0];
    assign laneWr   = (BWIDTH == 64 && bus.addr[2]) ? bus.wrData[BWIDTH-1 -: 32] : bus.wrData[31:0];

    assign hit      = bus.cs && ((bus.addr & ~32'h1F) == ADDR_BASE);
    assign offset   = bus.addr[4:0];
    assign wrEn     = hit && bus.we && (laneMask != '0);
    assign kick     = wrEn && (offset == OFF_CTRL);
    assign isEvt    = wrEn && offset[4] && (offset[1:0] == 2'b00);
    assign evtCode  = offset[3:2];
    assign resultWr = isEvt && (evtCode == EVT_PASS || evtCode == EVT_FAIL);
    assign wdExpire = (MAX_CLOCKS != 0) && (cycleCnt_q == 32'(MAX_CLOCKS - 1));
    assign done     = (state_q == ST_END);
    assign pushEvt  = '{code: evtCode, data: laneWr & laneMask};

    sim_mbox_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (isEvt),
        .pushData_i (pushEvt),
        .pop_i      (bus.evtRdy),
        .head_o     (headEvt),
        .headVld_o  (fifoVld),
        .full_o     (fifoFull)
    );

    // A result write outranks both a kick and a same-cycle watchdog expiry.
    always_comb begin
        state_d    = state_q;
        cycleCnt_d = cycleCnt_q;
        drainCnt_d = drainCnt_q;
        passed_d   = passed_q;
        failed_d   = failed_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (cycleCnt_q != '1) begin
                    cycleCnt_d = cycleCnt_q + 32'd1;
                end
                if (resultWr) begin
                    passed_d   = passed_q | (evtCode == EVT_PASS);
                    failed_d   = failed_q | (evtCode == EVT_FAIL);
                    state_d    = ST_DRAIN;
                    drainCnt_d = DW'(FINISH_DELAY - 1);
                end else if (kick) begin
                    cycleCnt_d = '0;
                end else if (wdExpire) begin
                    timeout_d  = 1'b1;
                    state_d    = ST_DRAIN;
                    drainCnt_d = DW'(FINISH_DELAY - 1);
                end
            end
            ST_DRAIN: begin
                if (drainCnt_q == '0) begin
                    state_d = ST_END;
                end else begin
                    drainCnt_d = drainCnt_q - 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        infoCnt_d = infoCnt_q;
        warnCnt_d = warnCnt_q;
        ovf_d     = ovf_q | (isEvt && fifoFull && !bus.evtRdy);
        if (isEvt && evtCode == EVT_INFO && infoCnt_q != 16'hFFFF) begin
            infoCnt_d = infoCnt_q + 16'd1;
        end
        if (isEvt && evtCode == EVT_WARN && warnCnt_q != 16'hFFFF) begin
            warnCnt_d = warnCnt_q + 16'd1;
        end
    end

    always_comb begin
        rdWord = '0;
        case (offset)
            OFF_CTRL:   rdWord = {25'b0, ovf_q, timeout_q, failed_q, passed_q, done, state_q};
            OFF_CYCLES: rdWord = cycleCnt_q;
            OFF_COUNTS: rdWord = {infoCnt_q, warnCnt_q};
            default:    rdWord = '0;
        endcase
        rdData_d = (hit && !bus.we) ? rdWord : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            cycleCnt_q <= '0;
            drainCnt_q <= '0;
            passed_q   <= 1'b0;
            failed_q   <= 1'b0;
            timeout_q  <= 1'b0;
            ovf_q      <= 1'b0;
            infoCnt_q  <= '0;
            warnCnt_q  <= '0;
            rdData_q   <= '0;
        end else begin
            state_q    <= state_d;
            cycleCnt_q <= cycleCnt_d;
            drainCnt_q <= drainCnt_d;
            passed_q   <= passed_d;
            failed_q   <= failed_d;
            timeout_q  <= timeout_d;
            ovf_q      <= ovf_d;
            infoCnt_q  <= infoCnt_d;
            warnCnt_q  <= warnCnt_d;
            rdData_q   <= rdData_d;
        end
    end

    assign bus.rdData  = {(BWIDTH / 32){rdData_q}};
    assign bus.evtVld  = fifoVld;
    assign bus.evtCode = headEvt.code;
    assign bus.evtData = headEvt.data;
    assign done_o      = done;
    assign passed_o    = passed_q;
    assign failed_o    = failed_q;
    assign timeout_o   = timeout_q;
    assign warnCnt_o   = warnCnt_q;

endmodule

// File: tb/tb_sim_status_mbox.sv
// Bench for sim_status_mbox: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a tick-based behavioural model.
module tb_sim_status_mbox;
    import sim_mbox_pkg::*;

    localparam int          BW    = 64;
    localparam int          MAXC  = 50;
    localparam int          FD    = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'hFFFFFFE0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        doneO, passedO, failedO, timeoutO;
    logic [15:0] warnCntO;

    int nTests = 0;
    int nFails = 0;

    sim_status_mbox_if #(.BWIDTH(BW)) bus ();

    sim_status_mbox #(
        .BWIDTH       (BW),
        .ADDR_BASE    (BASE),
        .MAX_CLOCKS   (MAXC),
        .FINISH_DELAY (FD),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .done_o    (doneO),
        .passed_o  (passedO),
        .failed_o  (failedO),
        .timeout_o (timeoutO),
        .warnCnt_o (warnCntO)
    );

    always #5 clk = ~clk;

    // Behavioural model: "done" is derived from the tick at which the test was
    // decided rather than from any down-counter.
    bit          armed = 0;
    bit          mRunning;
    longint      mTick, mDecide;
    longint      mCnt;
    bit          mPassed, mFailed, mTimeout, mOvf;
    int          mInfo, mWarn;
    logic [33:0] mQ[$];
    bit          rdChk;
    logic [31:0] rdExp;

    function automatic bit modelDone();
        return !mRunning && (mTick - mDecide >= FD);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] lm, lw;
        logic [4:0]  off;
        bit          hit, wr, isEvt, kick;
        int          code;
        int          st;
        if (rst) begin
            armed    = 1;
            mRunning = 1;
            mTick    = 0;
            mDecide  = 0;
            mCnt     = 0;
            mPassed  = 0;
            mFailed  = 0;
            mTimeout = 0;
            mOvf     = 0;
            mInfo    = 0;
            mWarn    = 0;
            mQ.delete();
            rdChk    = 1;
            rdExp    = '0;
        end else if (armed) begin
            hit   = bus.cs && ((bus.addr & ~32'h1F) == BASE);
            off   = bus.addr[4:0];
            lm    = bus.addr[2] ? bus.mask[63:32]   : bus.mask[31:0];
            lw    = bus.addr[2] ? bus.wrData[63:32] : bus.wrData[31:0];
            wr    = hit && bus.we && (lm != 0);
            kick  = wr && (off == 5'h00);
            isEvt = wr && (off inside {5'h10, 5'h14, 5'h18, 5'h1C});
            code  = (int'(off) - 16) / 4;

            rdChk = bus.cs && !bus.we;
            rdExp = '0;
            if (hit && !bus.we) begin
                st = mRunning ? 0 : (modelDone() ? 2 : 1);
                if (off == 5'h00)
                    rdExp = 32'(st) + (modelDone() ? 32'd4 : 32'd0) + (mPassed ? 32'd8 : 32'd0)
                          + (mFailed ? 32'd16 : 32'd0) + (mTimeout ? 32'd32 : 32'd0) + (mOvf ? 32'd64 : 32'd0);
                else if (off == 5'h04)
                    rdExp = 32'(mCnt);
                else if (off == 5'h08)
                    rdExp = 32'(mInfo) * 32'd65536 + 32'(mWarn);
            end

            if (bus.evtRdy && mQ.size() > 0) void'(mQ.pop_front());
            if (isEvt) begin
                if (mQ.size() < DEPTH) mQ.push_back({2'(code), lw & lm});
                else mOvf = 1;
                if (code == 0 && mInfo < 65535) mInfo++;
                if (code == 1 && mWarn < 65535) mWarn++;
            end

            mTick++;
            if (mRunning) begin
                if (isEvt && code == 2) mPassed = 1;
                else if (isEvt && code == 3) mFailed = 1;
                else if (!kick && MAXC != 0 && mCnt == MAXC - 1) mTimeout = 1;
                mCnt = kick ? 0 : (mCnt == 64'hFFFF_FFFF ? mCnt : mCnt + 1);
                if ((isEvt && code >= 2) || mTimeout) begin
                    mRunning = 0;
                    mDecide  = mTick;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checkOutput("evtVld", bus.evtVld, 64'(mQ.size() > 0));
            if (mQ.size() > 0) begin
                checkOutput("evtCode", bus.evtCode, 64'(mQ[0][33:32]));
                checkOutput("evtData", bus.evtData, 64'(mQ[0][31:0]));
            end
            checkOutput("done", doneO, 64'(modelDone()));
            checkOutput("passed", passedO, 64'(mPassed));
            checkOutput("failed", failedO, 64'(mFailed));
            checkOutput("timeout", timeoutO, 64'(mTimeout));
            checkOutput("warnCnt", warnCntO, 64'(mWarn));
            if (rdChk) checkOutput("rdData", bus.rdData, {rdExp, rdExp});
        end
    end

    task automatic applyStimulus(input bit cs, input bit we, input logic [31:0] addr,
                                 input logic [63:0] mask, input logic [63:0] data, input bit rdy);
        bus.cs     = cs;
        bus.we     = we;
        bus.addr   = addr;
        bus.mask   = mask;
        bus.wrData = data;
        bus.evtRdy = rdy;
        @(negedge clk);
        bus.cs     = 1'b0;
        bus.we     = 1'b0;
        bus.evtRdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 32'h0, 64'h0, 64'h0, 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [63:0] data, input logic [63:0] mask);
        applyStimulus(1, 1, addr, mask, data, 0);
    endtask

    task automatic busRead(input logic [31:0] addr);
        applyStimulus(1, 0, addr, 64'h0, 64'h0, 0);
    endtask

    localparam logic [63:0] LO = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] HI = 64'hFFFF_FFFF_0000_0000;

    initial begin
        int n;
        int sel;
        logic [31:0] a;
        logic [63:0] m;
        bus.cs = 0; bus.we = 0; bus.addr = 0; bus.mask = 0; bus.wrData = 0; bus.evtRdy = 0;
        @(negedge clk);

        doReset();
        checkOutput("resetVld", bus.evtVld, 0);
        checkOutput("resetCode", bus.evtCode, 0);
        checkOutput("resetData", bus.evtData, 0);
        checkOutput("resetFlags", {doneO, passedO, failedO, timeoutO}, 0);
        checkOutput("resetWarn", warnCntO, 0);
        checkOutput("resetRd", bus.rdData, 0);

        busWrite(32'hFFFFFFF0, {2{32'h12345678}}, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("infoVld", bus.evtVld, 1);
        checkOutput("infoCode", bus.evtCode, EVT_INFO);
        checkOutput("infoData", bus.evtData, 32'h12345678);
        busRead(32'hFFFFFFE8);
        checkOutput("countsRd", bus.rdData, 64'h00010000_00010000);
        busWrite(32'hFFFFFFF0, {2{32'hDEADBEEF}}, HI);
        busRead(32'hFFFFFFE8);
        checkOutput("maskZeroCounts", bus.rdData, 64'h00010000_00010000);
        checkOutput("maskZeroHead", bus.evtData, 32'h12345678);

        doReset();
        busWrite(32'hFFFFFFF8, 64'h0000CAFE, LO);
        checkOutput("passSet", passedO, 1);
        checkOutput("passNotDone", doneO, 0);
        idle(3);
        checkOutput("passDone3", doneO, 0);
        idle(1);
        checkOutput("passDone4", doneO, 1);
        busWrite(32'hFFFFFFFC, {32'h0BAD0BAD, 32'h0}, HI);
        checkOutput("lateFail", failedO, 0);
        checkOutput("passHeadCode", bus.evtCode, EVT_PASS);
        checkOutput("passHeadData", bus.evtData, 32'h0000CAFE);
        applyStimulus(0, 0, 32'h0, 64'h0, 64'h0, 1);
        checkOutput("failHeadCode", bus.evtCode, EVT_FAIL);
        checkOutput("failHeadData", bus.evtData, 32'h0BAD0BAD);
        busRead(32'hFFFFFFE0);
        checkOutput("passStatus", bus.rdData, {2{32'h0000000E}});

        doReset();
        idle(49);
        checkOutput("wdBefore", timeoutO, 0);
        idle(1);
        checkOutput("wdAt50", timeoutO, 1);
        idle(3);
        checkOutput("wdDone3", doneO, 0);
        idle(1);
        checkOutput("wdDone4", doneO, 1);
        busRead(32'hFFFFFFE0);
        checkOutput("wdStatus", bus.rdData, {2{32'h00000026}});

        doReset();
        repeat (5) begin
            busWrite(32'hFFFFFFE0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
            idle(39);
        end
        checkOutput("kickTimeout", timeoutO, 0);
        busRead(32'hFFFFFFE4);
        checkOutput("kickCycles", bus.rdData, {2{32'd39}});

        doReset();
        idle(49);
        busWrite(32'hFFFFFFFC, {32'h1, 32'h0}, HI);
        checkOutput("tieFailed", failedO, 1);
        checkOutput("tieTimeout", timeoutO, 0);

        doReset();
        for (int i = 0; i < 9; i++) busWrite(32'hFFFFFFF4, {32'(i + 100), 32'h0}, HI);
        checkOutput("ovfWarnCnt", warnCntO, 9);
        busRead(32'hFFFFFFE0);
        checkOutput("ovfStatus", bus.rdData, {2{32'h00000040}});
        n = 0;
        repeat (12) begin
            if (bus.evtVld) n++;
            applyStimulus(0, 0, 32'h0, 64'h0, 64'h0, 1);
        end
        checkOutput("ovfRetained", 64'(n), 8);

        doReset();
        busWrite(32'hFFFFFFF8, 64'h1, LO);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput("rstDrainVld", bus.evtVld, 0);
        checkOutput("rstDrainFlags", {doneO, passedO, failedO, timeoutO}, 0);
        checkOutput("rstDrainWarn", warnCntO, 0);
        busRead(32'hFFFFFFE0);
        checkOutput("rstDrainStatus", bus.rdData, 0);

        for (int r = 0; r < 6; r++) begin
            doReset();
            for (int c = 0; c < 250; c++) begin
                sel = int'($urandom_range(0, 9));
                if ((sel == 6 || sel == 7) && $urandom_range(0, 15) != 0) sel = 0;
                a = (sel == 9) ? 32'h0000_1010 : BASE + 32'(sel * 4);
                case ($urandom_range(0, 4))
                    0:       m = 64'h0;
                    1:       m = 64'hFFFF_FFFF_FFFF_FFFF;
                    2:       m = LO;
                    3:       m = HI;
                    default: m = {$urandom, $urandom};
                endcase
                if ($urandom_range(0, 299) == 0) rst = 1'b1;
                applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, a, m,
                              {$urandom, $urandom}, $urandom_range(0, 2) == 0);
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
